// File: rtl/ctrl_pkg.sv
// Shared constants for the multicycle controller and alu_control:
// state codes, opcode field values, alu_op codes and datapath select encodings.
package ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_RWB    = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_IEXEC  = 4'd10,
        S_IWB    = 4'd11
    } state_t;

    localparam logic [3:0] OP_R    = 4'b0000;
    localparam logic [3:0] OP_ADDI = 4'b0001;
    localparam logic [3:0] OP_ANDI = 4'b0010;
    localparam logic [3:0] OP_ORI  = 4'b0011;
    localparam logic [3:0] OP_NORI = 4'b0100;
    localparam logic [3:0] OP_BEQ  = 4'b0101;
    localparam logic [3:0] OP_SLTI = 4'b0110;
    localparam logic [3:0] OP_LW   = 4'b0111;
    localparam logic [3:0] OP_SW   = 4'b1000;
    localparam logic [3:0] OP_J    = 4'b1001;

    localparam logic [2:0] ALU_FUNCT = 3'b000;
    localparam logic [2:0] ALU_ADD   = 3'b001;
    localparam logic [2:0] ALU_AND   = 3'b010;
    localparam logic [2:0] ALU_OR    = 3'b011;
    localparam logic [2:0] ALU_NOR   = 3'b100;
    localparam logic [2:0] ALU_SUB   = 3'b101;
    localparam logic [2:0] ALU_SLT   = 3'b110;

    localparam logic [1:0] SRCB_REG     = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    function automatic logic is_undefined(input logic [3:0] op);
        return op > OP_J;
    endfunction

    // Dispatch out of DECODE; undefined opcodes fall back to FETCH.
    function automatic state_t decode_next(input logic [3:0] op);
        case (op)
            OP_R:                                   return S_EXEC;
            OP_LW, OP_SW:                           return S_MEMADR;
            OP_BEQ:                                 return S_BRANCH;
            OP_J:                                   return S_JUMP;
            OP_ADDI, OP_ANDI, OP_ORI, OP_NORI,
            OP_SLTI:                                return S_IEXEC;
            default:                                return S_FETCH;
        endcase
    endfunction

endpackage

// File: rtl/imm_aluop_dec.sv
// Maps an immediate-class opcode to the ALU operation used in IEXEC.
module imm_aluop_dec
    import ctrl_pkg::*;
(
    input  logic [3:0] i_opcode,
    output logic [2:0] o_alu_op
);

    always_comb begin
        case (i_opcode)
            OP_ADDI: o_alu_op = ALU_ADD;
            OP_ANDI: o_alu_op = ALU_AND;
            OP_ORI:  o_alu_op = ALU_OR;
            OP_NORI: o_alu_op = ALU_NOR;
            OP_SLTI: o_alu_op = ALU_SLT;
            default: o_alu_op = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS-style main controller: one registered state, all datapath
// strobes and selects decoded combinationally from it (and mem_ready where used).
//
// state  | meaning
// FETCH  | read instruction, PC += 4 when memory ready
// DECODE | dispatch on opcode, precompute branch target
// MEMADR | effective address for lw/sw
// MEMRD  | load data read, waits on mem_ready
// MEMWB  | load writeback to rt
// MEMWR  | store write, waits on mem_ready
// EXEC   | R-type ALU operation
// RWB    | R-type writeback to rd
// BRANCH | beq compare and conditional PC update
// JUMP   | unconditional PC update
// IEXEC  | immediate ALU operation
// IWB    | immediate writeback to rt
module multicycle_control
    import ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       ir_write,
    output logic       mem_read,
    output logic       mem_write,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_source,
    output logic [2:0] alu_op,
    output logic       done,
    output logic       illegal,
    output logic [3:0] state
);

    state_t     r_state;
    logic [2:0] w_imm_alu_op;

    imm_aluop_dec u_imm_aluop_dec (
        .i_opcode (opcode),
        .o_alu_op (w_imm_alu_op)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_FETCH;
        end else begin
            case (r_state)
                S_FETCH:  if (mem_ready) r_state <= S_DECODE;
                S_DECODE: r_state <= decode_next(opcode);
                S_MEMADR: r_state <= (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
                S_MEMRD:  if (mem_ready) r_state <= S_MEMWB;
                S_MEMWR:  if (mem_ready) r_state <= S_FETCH;
                S_EXEC:   r_state <= S_RWB;
                S_IEXEC:  r_state <= S_IWB;
                default:  r_state <= S_FETCH;
            endcase
        end
    end

    // Outputs are forced to zero for the whole time rst is high, not only after the edge.
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        ir_write      = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        reg_write     = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = SRCB_REG;
        pc_source     = PCSRC_ALU;
        alu_op        = ALU_FUNCT;
        done          = 1'b0;
        illegal       = 1'b0;
        state         = 4'd0;
        if (!rst) begin
            state = r_state;
            case (r_state)
                S_FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = SRCB_FOUR;
                    alu_op    = ALU_ADD;
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                end
                S_DECODE: begin
                    alu_src_b = SRCB_IMM_SH2;
                    alu_op    = ALU_ADD;
                    illegal   = is_undefined(opcode);
                end
                S_MEMADR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = SRCB_IMM;
                    alu_op    = ALU_ADD;
                end
                S_MEMRD: mem_read = 1'b1;
                S_MEMWB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                    done       = 1'b1;
                end
                S_MEMWR: begin
                    mem_write = 1'b1;
                    done      = mem_ready;
                end
                S_EXEC: alu_src_a = 1'b1;
                S_RWB: begin
                    reg_write = 1'b1;
                    reg_dst   = 1'b1;
                    done      = 1'b1;
                end
                S_BRANCH: begin
                    alu_src_a     = 1'b1;
                    alu_op        = ALU_SUB;
                    pc_write_cond = 1'b1;
                    pc_source     = PCSRC_ALUOUT;
                    done          = 1'b1;
                end
                S_JUMP: begin
                    pc_write  = 1'b1;
                    pc_source = PCSRC_JUMP;
                    done      = 1'b1;
                end
                S_IEXEC: begin
                    alu_src_a = 1'b1;
                    alu_src_b = SRCB_IMM;
                    alu_op    = w_imm_alu_op;
                end
                S_IWB: begin
                    reg_write = 1'b1;
                    done      = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: directed table, reset corner
// sequences and randomized instruction streams against a per-instruction cycle model.
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] opcode;
    logic       mem_ready;
    logic       pc_write, pc_write_cond, ir_write, mem_read, mem_write, reg_write;
    logic       reg_dst, mem_to_reg, alu_src_a, done, illegal;
    logic [1:0] alu_src_b, pc_source;
    logic [2:0] alu_op;
    logic [3:0] state;

    always #5 clk = ~clk;

    multicycle_control dut (
        .clk           (clk),
        .rst           (rst),
        .opcode        (opcode),
        .mem_ready     (mem_ready),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .ir_write      (ir_write),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .reg_write     (reg_write),
        .reg_dst       (reg_dst),
        .mem_to_reg    (mem_to_reg),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .pc_source     (pc_source),
        .alu_op        (alu_op),
        .done          (done),
        .illegal       (illegal),
        .state         (state)
    );

    typedef struct packed {
        logic [3:0] st;
        logic       pc_write, pc_write_cond, ir_write, mem_read, mem_write, reg_write;
        logic       reg_dst, mem_to_reg, alu_src_a;
        logic [1:0] alu_src_b, pc_source;
        logic [2:0] alu_op;
        logic       done, illegal;
    } outs_t;

    typedef struct {
        logic  mr;
        outs_t o;
    } step_t;

    typedef struct {
        logic [3:0] op;
        int         mw;
        int         cycles;
        logic [3:0] key_state;
        logic [2:0] key_alu;
    } vec_t;

    int total = 0;
    int bad   = 0;

    step_t      q[$];
    int         cyc, meas;
    logic [3:0] key_state;
    logic       key_seen;
    logic [2:0] key_alu;

    function automatic outs_t sample();
        outs_t a;
        a.st = state;
        a.pc_write = pc_write;       a.pc_write_cond = pc_write_cond;
        a.ir_write = ir_write;       a.mem_read = mem_read;
        a.mem_write = mem_write;     a.reg_write = reg_write;
        a.reg_dst = reg_dst;         a.mem_to_reg = mem_to_reg;
        a.alu_src_a = alu_src_a;     a.alu_src_b = alu_src_b;
        a.pc_source = pc_source;     a.alu_op = alu_op;
        a.done = done;               a.illegal = illegal;
        return a;
    endfunction

    task automatic chk(input string name, input outs_t a, input outs_t e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %h expected %h (state got %0d exp %0d)", name, a, e, a.st, e.st);
        end
    endtask

    task automatic chk_int(input string name, input int a, input int e);
        total++;
        if (a != e) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, a, e);
        end
    endtask

    // ALU operation an immediate instruction should request.
    function automatic logic [2:0] imm_alu(input logic [3:0] op);
        case (op)
            4'd1:    return 3'b001;
            4'd2:    return 3'b010;
            4'd3:    return 3'b011;
            4'd4:    return 3'b100;
            default: return 3'b110;
        endcase
    endfunction

    function automatic outs_t at(input logic [3:0] s);
        outs_t o = '0;
        o.st = s;
        return o;
    endfunction

    function automatic logic nz(input bit noise);
        return noise ? logic'($urandom_range(0, 1)) : 1'b1;
    endfunction

    // Expected per-cycle behaviour of one whole instruction, FETCH through completion.
    task automatic build(input logic [3:0] op, input int fw, input int mw, input bit noise);
        outs_t o;
        q.delete();
        o = at(4'd0); o.mem_read = 1; o.alu_src_b = 2'b01; o.alu_op = 3'b001;
        for (int i = 0; i < fw; i++) q.push_back('{1'b0, o});
        o.ir_write = 1; o.pc_write = 1;
        q.push_back('{1'b1, o});
        o = at(4'd1); o.alu_src_b = 2'b11; o.alu_op = 3'b001; o.illegal = (op >= 4'd10);
        q.push_back('{nz(noise), o});
        if (op >= 4'd10) return;
        case (op)
            4'd0: begin
                o = at(4'd6); o.alu_src_a = 1;
                q.push_back('{nz(noise), o});
                o = at(4'd7); o.reg_write = 1; o.reg_dst = 1; o.done = 1;
                q.push_back('{nz(noise), o});
            end
            4'd5: begin
                o = at(4'd8); o.alu_src_a = 1; o.alu_op = 3'b101; o.pc_write_cond = 1;
                o.pc_source = 2'b01; o.done = 1;
                q.push_back('{nz(noise), o});
            end
            4'd9: begin
                o = at(4'd9); o.pc_write = 1; o.pc_source = 2'b10; o.done = 1;
                q.push_back('{nz(noise), o});
            end
            4'd7, 4'd8: begin
                o = at(4'd2); o.alu_src_a = 1; o.alu_src_b = 2'b10; o.alu_op = 3'b001;
                q.push_back('{nz(noise), o});
                if (op == 4'd7) begin
                    o = at(4'd3); o.mem_read = 1;
                    for (int i = 0; i < mw; i++) q.push_back('{1'b0, o});
                    q.push_back('{1'b1, o});
                    o = at(4'd4); o.reg_write = 1; o.mem_to_reg = 1; o.done = 1;
                    q.push_back('{nz(noise), o});
                end else begin
                    o = at(4'd5); o.mem_write = 1;
                    for (int i = 0; i < mw; i++) q.push_back('{1'b0, o});
                    o.done = 1;
                    q.push_back('{1'b1, o});
                end
            end
            default: begin
                o = at(4'd10); o.alu_src_a = 1; o.alu_src_b = 2'b10; o.alu_op = imm_alu(op);
                q.push_back('{nz(noise), o});
                o = at(4'd11); o.reg_write = 1; o.done = 1;
                q.push_back('{nz(noise), o});
            end
        endcase
    endtask

    // Entered and left at posedge+1; drives mem_ready, checks at negedge.
    task automatic step(input logic mr, input outs_t e, input string name);
        outs_t a;
        mem_ready = mr;
        @(negedge clk);
        a = sample();
        cyc++;
        if (meas == 0 && (a.done || a.illegal)) meas = cyc;
        if (!key_seen && a.st == key_state) begin
            key_seen = 1'b1;
            key_alu  = a.alu_op;
        end
        chk(name, a, e);
        @(posedge clk);
        #1;
    endtask

    task automatic run_instr(input logic [3:0] op, input int fw, input int mw,
                             input bit noise, input string name);
        cyc = 0; meas = 0; key_seen = 1'b0; key_alu = 3'bxxx;
        opcode = op;
        build(op, fw, mw, noise);
        foreach (q[i]) step(q[i].mr, q[i].o, name);
    endtask

    vec_t vecs[$];
    outs_t fetch_wait;

    initial begin
        vecs = '{
            '{4'd0,  0, 4, 4'd6,  3'b000},
            '{4'd1,  0, 4, 4'd10, 3'b001},
            '{4'd2,  0, 4, 4'd10, 3'b010},
            '{4'd3,  0, 4, 4'd10, 3'b011},
            '{4'd4,  0, 4, 4'd10, 3'b100},
            '{4'd5,  0, 3, 4'd8,  3'b101},
            '{4'd6,  0, 4, 4'd10, 3'b110},
            '{4'd7,  0, 5, 4'd2,  3'b001},
            '{4'd7,  3, 8, 4'd3,  3'b000},
            '{4'd8,  0, 4, 4'd5,  3'b000},
            '{4'd8,  2, 6, 4'd2,  3'b001},
            '{4'd9,  0, 3, 4'd9,  3'b000},
            '{4'd12, 0, 2, 4'd1,  3'b001},
            '{4'd15, 0, 2, 4'd1,  3'b001}
        };
        fetch_wait = at(4'd0);
        fetch_wait.mem_read = 1; fetch_wait.alu_src_b = 2'b01; fetch_wait.alu_op = 3'b001;
        key_state = 4'hf; key_seen = 1'b1; cyc = 0; meas = 0;

        rst = 1'b1; mem_ready = 1'b1; opcode = 4'd9;
        repeat (2) @(posedge clk);
        #1;
        step(1'b1, '0, "reset_hold");
        rst = 1'b0;

        foreach (vecs[i]) begin
            key_state = vecs[i].key_state;
            run_instr(vecs[i].op, 0, vecs[i].mw, 1'b0, $sformatf("vec%0d_op%0d", i, vecs[i].op));
            chk_int($sformatf("vec%0d_cycles", i), meas, vecs[i].cycles);
            chk_int($sformatf("vec%0d_key_alu_op", i), int'(key_alu), int'(vecs[i].key_alu));
        end
        key_state = 4'hf;

        // Reset asserted mid-EXEC, held a second cycle, then released.
        opcode = 4'd0;
        build(4'd0, 0, 0, 1'b0);
        step(q[0].mr, q[0].o, "rexec_fetch");
        step(q[1].mr, q[1].o, "rexec_decode");
        rst = 1'b1;
        step(1'b1, '0, "rexec_in_exec");
        step(1'b1, '0, "rexec_next_cycle");
        rst = 1'b0;
        step(1'b0, fetch_wait, "rexec_release_fetch");
        step(1'b0, fetch_wait, "fetch_hold_no_ready");

        // Reset asserted while a load waits on memory.
        opcode = 4'd7;
        build(4'd7, 0, 5, 1'b0);
        for (int i = 0; i < 5; i++) step(q[i].mr, q[i].o, "rmemrd_pre");
        rst = 1'b1;
        step(1'b0, '0, "rmemrd_in_wait");
        rst = 1'b0;
        step(1'b0, fetch_wait, "rmemrd_release_fetch");

        for (int n = 0; n < 150; n++) begin
            logic [3:0] op;
            op = 4'($urandom_range(0, 15));
            run_instr(op, $urandom_range(0, 2), $urandom_range(0, 3), 1'b1,
                      $sformatf("rand%0d_op%0d", n, op));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 clk  in  1  rising-edge clock for all state.
REQ-002 rst  in  1  synchronous active-high reset, sampled on rising clk edge.
REQ-003 opcode  in  4  instruction-register opcode field, valid from DECODE onward.
REQ-004 mem_ready  in  1  memory handshake; access completes in the cycle it is high.
REQ-005 pc_write, pc_write_cond, ir_write, mem_read, mem_write, reg_write  out  1 each  datapath strobes.
REQ-006 reg_dst, mem_to_reg, alu_src_a  out  1 each  mux selects (reg_dst 1=rd; mem_to_reg 1=MDR; alu_src_a 1=reg A, 0=PC).
REQ-007 alu_src_b  out  2  00=reg B, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2.
REQ-008 pc_source  out  2  00=ALU result, 01=ALUOut, 10=jump target.
REQ-009 alu_op  out  3  to alu_control: 000 R-type(funct), 001 add, 010 and, 011 or, 100 nor, 101 sub, 110 slt.
REQ-010 done  out  1  one-cycle pulse in final cycle of each instruction; illegal  out  1  one-cycle pulse on undefined opcode.
REQ-011 state  out  4  current state code, for debug.

Function
REQ-012 Opcodes: 0000 R, 0001 addi, 0010 andi, 0011 ori, 0100 nori, 0101 beq, 0110 slti, 0111 lw, 1000 sw, 1001 j; 1010-1111 undefined.
REQ-013 States/codes: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, RWB 7, BRANCH 8, JUMP 9, IEXEC 10, IWB 11; codes 12-15 go to FETCH next cycle.
REQ-014 FETCH: mem_read=1, alu_src_a=0, alu_src_b=01, alu_op=001, pc_source=00; ir_write=pc_write=mem_ready; stay while mem_ready=0, else DECODE.
REQ-015 DECODE: alu_src_a=0, alu_src_b=11, alu_op=001; next: R->EXEC, lw/sw->MEMADR, beq->BRANCH, j->JUMP, addi/andi/ori/nori/slti->IEXEC, undefined->FETCH with illegal=1 and done=0.
REQ-016 MEMADR: alu_src_a=1, alu_src_b=10, alu_op=001; lw->MEMRD, sw->MEMWR.
REQ-017 MEMRD: mem_read=1; wait on mem_ready=0, else MEMWB. MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0, done=1 -> FETCH.
REQ-018 MEMWR: mem_write=1; wait on mem_ready=0; on mem_ready=1 done=1 -> FETCH.
REQ-019 EXEC: alu_src_a=1, alu_src_b=00, alu_op=000 -> RWB. RWB: reg_write=1, reg_dst=1, mem_to_reg=0, done=1 -> FETCH.
REQ-020 BRANCH: alu_src_a=1, alu_src_b=00, alu_op=101, pc_write_cond=1, pc_source=01, done=1 -> FETCH.
REQ-021 JUMP: pc_write=1, pc_source=10, done=1 -> FETCH.
REQ-022 IEXEC: alu_src_a=1, alu_src_b=10, alu_op = addi 001, andi 010, ori 011, nori 100, slti 110 -> IWB. IWB: reg_write=1, reg_dst=0, mem_to_reg=0, done=1 -> FETCH.
REQ-023 Any strobe/select not listed for a state SHALL be 0; all outputs decode combinationally from registered state (plus mem_ready where stated).
REQ-024 mem_ready is ignored outside FETCH, MEMRD, MEMWR; no timeout, wait is unbounded.
REQ-025 Cycle counts with mem_ready=1 throughout: R/imm 4, lw 5, sw 4, beq 3, j 3, undefined 2.

Reset
REQ-026 rst=1 at a clk edge SHALL load FETCH regardless of current state, including mid-instruction or mid-wait.
REQ-027 While rst=1, all strobes, done, illegal SHALL be 0, selects and alu_op 0, state=0.
REQ-028 First FETCH cycle after rst deasserts SHALL behave per REQ-014.

Structure
REQ-029 State codes, opcode constants and alu_op constants SHALL live in shared package ctrl_pkg, also used by alu_control.
REQ-030 One sub-module imm_aluop_dec (opcode in 4 -> alu_op out 3, combinational) SHALL implement the REQ-022 mapping.

Verification
REQ-031 Reset: rst=1 from EXEC -> next cycle state=0, all strobes 0; release -> FETCH with mem_read=1.
REQ-032 R-type, opcode 0000, mem_ready=1 -> states 0,1,6,7; RWB reg_write=1, reg_dst=1, done=1; EXEC alu_op=000.
REQ-033 lw, opcode 0111, mem_ready low 3 cycles in MEMRD -> MEMRD held 4 cycles, then MEMWB mem_to_reg=1, done=1; total 8 cycles.
REQ-034 ori 0011 -> IEXEC alu_op=011, alu_src_b=10; slti 0110 -> alu_op=110.
REQ-035 beq 0101 -> BRANCH alu_op=101, pc_write_cond=1, pc_source=01; j 1001 -> JUMP pc_write=1, pc_source=10.
REQ-036 Undefined 1100 -> DECODE illegal=1, done=0, next state 0; FETCH with mem_ready=0 -> ir_write=pc_write=0, state held.
